// File: rtl/dct_transpose_buf.sv
// Two-bank transpose buffer: one N-element row in per cycle, one column out per cycle, sign-extended to OW.
// First column is valid the cycle after a block's last row; in_ready drops only while both banks hold unread blocks.
module dct_transpose_buf #(
   parameter  int N  = 8,
   parameter  int IW = 12,
   parameter  int OW = 16,
   localparam int LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*IW-1:0] in_row,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*OW-1:0] out_col,
   output logic [LW-1:0]   out_idx,
   output logic            out_last
);

   logic [IW-1:0] mem_q [2][N][N];

   logic [1:0]    full_q, full_d;
   logic          wsel_q, wsel_d;
   logic          rsel_q, rsel_d;
   logic [LW-1:0] row_cnt_q, row_cnt_d;
   logic [LW-1:0] col_cnt_q, col_cnt_d;

   logic in_acc, out_acc, wr_done, rd_done;

   assign in_ready  = !full_q[wsel_q];
   assign out_valid = full_q[rsel_q];
   assign out_idx   = col_cnt_q;
   assign out_last  = out_valid && (col_cnt_q == LW'(N - 1));

   assign in_acc  = in_valid && in_ready;
   assign out_acc = out_valid && out_ready;
   assign wr_done = in_acc && (row_cnt_q == LW'(N - 1));
   assign rd_done = out_acc && (col_cnt_q == LW'(N - 1));

   always_comb begin
      full_d    = full_q;
      wsel_d    = wsel_q;
      rsel_d    = rsel_q;
      row_cnt_d = row_cnt_q;
      col_cnt_d = col_cnt_q;
      if (flush) begin
         full_d    = 2'b00;
         wsel_d    = 1'b0;
         rsel_d    = 1'b0;
         row_cnt_d = '0;
         col_cnt_d = '0;
      end else begin
         // wr_done needs !full[wsel], rd_done needs full[rsel]: never the same bank
         if (in_acc) begin
            row_cnt_d = wr_done ? '0 : LW'(row_cnt_q + 1'b1);
         end
         if (wr_done) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = !wsel_q;
         end
         if (out_acc) begin
            col_cnt_d = rd_done ? '0 : LW'(col_cnt_q + 1'b1);
         end
         if (rd_done) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = !rsel_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full_q    <= 2'b00;
         wsel_q    <= 1'b0;
         rsel_q    <= 1'b0;
         row_cnt_q <= '0;
         col_cnt_q <= '0;
      end else begin
         full_q    <= full_d;
         wsel_q    <= wsel_d;
         rsel_q    <= rsel_d;
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
      end
   end

   // Storage is not reset; full_q alone decides what is readable.
   always_ff @(posedge clk) begin
      if (in_acc && !flush) begin
         for (int k = 0; k < N; k++) begin
            mem_q[wsel_q][row_cnt_q][k] <= in_row[k*IW +: IW];
         end
      end
   end

   always_comb begin
      out_col = '0;
      if (out_valid) begin
         for (int r = 0; r < N; r++) begin
            out_col[r*OW +: OW] = OW'($signed(mem_q[rsel_q][r][col_cnt_q]));
         end
      end
   end

   a_no_same_bank: assert property (@(posedge clk) disable iff (!rstn)
      !(wr_done && rd_done && (wsel_q == rsel_q)));

   a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
      (out_valid && !out_ready && !flush) |=> ($stable(out_col) && $stable(out_idx)));

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Randomized and directed bench for dct_transpose_buf against a block-queue reference model.
module tb_dct_transpose_buf;
   localparam int N  = 8;
   localparam int IW = 12;
   localparam int OW = 16;
   localparam int LW = 3;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [N*IW-1:0] in_row = '0;
   logic            in_ready;
   logic            out_valid;
   logic [N*OW-1:0] out_col;
   logic [LW-1:0]   out_idx;
   logic            out_last;

   dct_transpose_buf #(.N(N), .IW(IW), .OW(OW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_row   (in_row),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_col  (out_col),
      .out_idx  (out_idx),
      .out_last (out_last)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int stall_cnt = 0;

   task automatic chk(input string tag, input logic [N*OW-1:0] got, input logic [N*OW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: queue of complete blocks awaiting readout, plus the block being filled.
   typedef int unsigned blk_t [N*N];
   blk_t m_q[$];
   blk_t m_part;
   int   m_rows = 0;
   int   m_col  = 0;

   function automatic void m_clear();
      m_q.delete();
      m_rows = 0;
      m_col  = 0;
   endfunction

   function automatic logic [N*OW-1:0] m_exp_col();
      logic [N*OW-1:0] res;
      longint e;
      res = '0;
      if (m_q.size() == 0) return res;
      for (int r = 0; r < N; r++) begin
         e = longint'(m_q[0][r*N + m_col]);
         if (e >= (longint'(1) << (IW - 1))) e = e + (longint'(1) << OW) - (longint'(1) << IW);
         res[r*OW +: OW] = e[OW-1:0];
      end
      return res;
   endfunction

   function automatic logic [N*IW-1:0] rand_row();
      logic [N*IW-1:0] row;
      for (int k = 0; k < N; k++) row[k*IW +: IW] = IW'($urandom);
      return row;
   endfunction

   function automatic logic [N*IW-1:0] seq_row(input int r);
      logic [N*IW-1:0] row;
      for (int k = 0; k < N; k++) row[k*IW +: IW] = IW'(r*8 + k);
      return row;
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input logic v, input logic [N*IW-1:0] row, input logic ordy, input logic fl);
      logic acc_in, acc_out;
      in_valid  = v;
      in_row    = row;
      out_ready = ordy;
      flush     = fl;
      #1;
      chk("in_ready",  N*OW'(in_ready),  N*OW'(m_q.size() < 2));
      chk("out_valid", N*OW'(out_valid), N*OW'(m_q.size() > 0));
      chk("out_idx",   N*OW'(out_idx),   N*OW'(m_col));
      chk("out_last",  N*OW'(out_last),  N*OW'((m_q.size() > 0) && (m_col == N - 1)));
      chk("out_col",   out_col,          m_exp_col());
      if (v && !in_ready) stall_cnt++;
      acc_in  = v && (m_q.size() < 2);
      acc_out = ordy && (m_q.size() > 0);
      @(posedge clk);
      if (fl) begin
         m_clear();
      end else begin
         if (acc_out) begin
            m_col++;
            if (m_col == N) begin
               m_col = 0;
               void'(m_q.pop_front());
            end
         end
         if (acc_in) begin
            for (int k = 0; k < N; k++) m_part[m_rows*N + k] = int'(row[k*IW +: IW]);
            m_rows++;
            if (m_rows == N) begin
               m_q.push_back(m_part);
               m_rows = 0;
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [N*OW-1:0] exp_c;
      logic [N*OW-1:0] snap;
      logic [N*IW-1:0] r17;
      logic [IW-1:0]   sx_in [3];
      logic [OW-1:0]   sx_out [3];
      int nvalid, nout_win;

      sx_in[0]  = 12'hFFF; sx_in[1]  = 12'h800; sx_in[2]  = 12'h7FF;
      sx_out[0] = 16'hFFFF; sx_out[1] = 16'hF800; sx_out[2] = 16'h07FF;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready",  N*OW'(in_ready),  N*OW'(1));
      chk("rst_out_valid", N*OW'(out_valid), '0);
      chk("rst_out_col",   out_col,          '0);
      chk("rst_out_idx",   N*OW'(out_idx),   '0);
      @(negedge clk);
      rstn = 1'b1;
      m_clear();

      // Single block, element value r*8+k.
      for (int r = 0; r < N; r++) step(1'b1, seq_row(r), 1'b1, 1'b0);
      chk("t2_first_valid", N*OW'(out_valid), N*OW'(1));
      for (int c = 0; c < N; c++) begin
         for (int r = 0; r < N; r++) exp_c[r*OW +: OW] = OW'(r*8 + c);
         chk("t2_col", out_col, exp_c);
         chk("t2_last", N*OW'(out_last), N*OW'(c == N - 1));
         step(1'b0, '0, 1'b1, 1'b0);
      end
      chk("t2_drained", N*OW'(out_valid), '0);

      // Three blocks back to back with a free-running sink.
      stall_cnt = 0;
      nvalid    = 0;
      nout_win  = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin
            nvalid++;
            if (i < 8 || i > 31) nout_win++;
         end
         step(i < 24, rand_row(), 1'b1, 1'b0);
      end
      chk("t3_no_stall",   N*OW'(stall_cnt), '0);
      chk("t3_col_count",  N*OW'(nvalid),    N*OW'(24));
      chk("t3_col_window", N*OW'(nout_win),  '0);

      // Backpressure: two banks fill, 17th row waits.
      for (int i = 0; i < 16; i++) step(1'b1, rand_row(), 1'b0, 1'b0);
      r17 = rand_row();
      chk("t4_in_ready_low", N*OW'(in_ready), '0);
      snap = out_col;
      for (int i = 0; i < 3; i++) step(1'b1, rand_row(), 1'b0, 1'b0);
      chk("t4_hold_col", out_col, snap);
      chk("t4_hold_idx", N*OW'(out_idx), '0);
      for (int i = 0; i < N; i++) step(1'b1, r17, 1'b1, 1'b0);
      chk("t4_ready_after_drain", N*OW'(in_ready), N*OW'(1));
      step(1'b1, r17, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);

      // Sign extension of extreme codes.
      for (int r = 0; r < N; r++) begin
         logic [N*IW-1:0] row;
         for (int k = 0; k < N; k++) row[k*IW +: IW] = sx_in[r % 3];
         step(1'b1, row, 1'b0, 1'b0);
      end
      for (int r = 0; r < N; r++) exp_c[r*OW +: OW] = sx_out[r % 3];
      chk("t5_sext", out_col, exp_c);
      for (int i = 0; i < N; i++) step(1'b0, '0, 1'b1, 1'b0);

      // Flush mid-fill, then mid-readout.
      for (int r = 0; r < 5; r++) step(1'b1, rand_row(), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("t6_flush_fill", N*OW'(out_valid), '0);
      for (int r = 0; r < N; r++) step(1'b1, rand_row(), 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, 1'b0);
      chk("t6_at_col3", N*OW'(out_idx), N*OW'(3));
      step(1'b0, '0, 1'b1, 1'b1);
      chk("t6_flush_read", N*OW'(out_valid), '0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("t6_no_stale", N*OW'(out_valid), '0);
      for (int r = 0; r < N; r++) step(1'b1, rand_row(), 1'b1, 1'b0);
      for (int c = 0; c < N + 2; c++) step(1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset with data pending in both banks.
      for (int i = 0; i < 13; i++) step(1'b1, rand_row(), 1'b0, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      chk("t1_in_ready",  N*OW'(in_ready),  N*OW'(1));
      chk("t1_out_valid", N*OW'(out_valid), '0);
      chk("t1_out_col",   out_col,          '0);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      m_clear();
      for (int r = 0; r < N; r++) step(1'b1, seq_row(r), 1'b1, 1'b0);
      for (int r = 0; r < N; r++) exp_c[r*OW +: OW] = OW'(r*8);
      chk("t1_block0_col0", out_col, exp_c);
      for (int c = 0; c < N; c++) step(1'b0, '0, 1'b1, 1'b0);

      // Random traffic with occasional flush.
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 3) != 0, rand_row(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 199) == 0);
      end
      for (int i = 0; i < 3*N; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("final_empty", N*OW'(out_valid), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
